control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the Mini SRC datapath. Runs fetch (T0-T2) and execute (T3-T6) per instruction.
//  Drives every datapath strobe (e_*, incPC, MDR_read, BusDataSelect, GP_addr, ALU_op) from its state and IR fields.
//  Sits beside datapath at CPU top level. Waits on a memory-ready handshake and signals completion or halt.
// PARAMETERS
//  IR_W        32  instruction width (IR input from datapath)
//  BUS_SEL_W   5   BusDataSelect width
//  ALU_OP_W    4   ALU_op width
//  MEM_TMO     15  max T1 wait cycles before mem_err
// PORTS
//  clock         in   1   single clock, rising edge
//  clear         in   1   asynchronous, active-low reset (0 = reset)
//  run           in   1   level; leaves IDLE when 1
//  mem_ready     in   1   memory read data valid on Mdatain this cycle
//  IR            in   32  current IR register contents from datapath
//  e_PC,e_IR,e_Y,e_Z,e_HI,e_LO,e_MDR,e_MAR,e_GP  out 1 each  register load enables
//  incPC         out  1   datapath Z <= PC+1 select
//  MDR_read      out  1   MDR source = Mdatain
//  ALU_op        out  4   ALU operation
//  BusDataSelect out  5   bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR
//  GP_addr       out  4   GP write address
//  instr_done    out  1   1-cycle pulse on last execute cycle
//  halted        out  1   1 in HALTED
//  illegal_op    out  1   1-cycle pulse in T3 on undefined opcode
//  mem_err       out  1   sticky until reset; set on T1 timeout
// BEHAVIOUR
//  Reset (clear=0, async): state=IDLE. All outputs 0, BusDataSelect=0, wait counter=0, mem_err=0.
//  Outputs are decoded combinationally from state + IR fields. Only enables listed for a state are 1.
//  IR fields: opc=IR[31:27], Ra=IR[26:23] (dest), Rb=IR[22:19], Rc=IR[18:15].
//  IDLE: all 0; run=1 -> T0.
//  T0: Bus=PC(20), e_MAR, incPC, e_Z -> T1.
//  T1: Bus=ZLO(19), e_PC; MDR_read=e_MDR=mem_ready.
//   mem_ready=1 -> T2; else stay in T1 and counter++.
//   counter==MEM_TMO with mem_ready=0 -> set mem_err, go to IDLE.
//   PC is reloaded with the same value every wait cycle (harmless). Counter clears on T1 exit.
//  T2: Bus=MDR(21), e_IR -> T3.
//  T3: decode opc.
//   HALT(0x1F) -> HALTED, no enables.
//   undefined -> pulse illegal_op, instr_done, go to T0 (treated as NOP).
//   else Bus=Rb, e_Y -> T4.
//  T4: Bus=Rc, ALU_op=op_map(opc), e_Z -> T5.
//  T5: R-type: Bus=ZLO, GP_addr=Ra, e_GP, instr_done -> T0.
//   MUL/DIV: Bus=ZLO, e_LO -> T6.
//  T6 (MUL/DIV only): Bus=ZHI(18), e_HI, instr_done -> T0.
//  HALTED: halted=1, all enables 0; exit only via reset.
//  run is sampled only in IDLE; dropping run mid-instruction does not abort.
//  Latency: R-type 6 cycles + T1 waits; MUL/DIV 7 cycles + T1 waits.
//  Opcode map: ADD 03->0000, SUB 04->0001, AND 05->0010, OR 06->0011, SHR 07->0100,
//   SHL 08->0101, SHRA 09->0110, ROL 0A->1001, ROR 0B->1010, NEG 0C->0111,
//   NOT 0D->1000, MUL 0E->1011, DIV 0F->1100, HALT 1F. All others undefined.
//  NEG/NOT: T3 still loads Y from Rb (ignored); T4 uses Rc.
// CONFIGURATION
//  CONTROL_SINGLE_STEP_EN defined: after instr_done go to IDLE, not T0.
//   Re-enter T0 only on a run 0->1 edge, using a registered run_q.
//   Illegal opcode also returns to IDLE.
//  Undefined: free-running; instr_done -> T0 while run is ignored.
// STRUCTURE
//  Package ctrl_pkg: state enum, BUS_* select constants, OPC_* opcodes, ALU_* codes,
//   op_map() function, is_hilo() function.
//  No sub-module. One state register, one wait counter, one combinational output decode.
// TESTING
//  1. Reset mid-T4 (clear=0): all outputs 0 the same cycle; IDLE after clear=1 and no motion until run=1.
//  2. run=1, mem_ready=1, IR=ROR R4,R3,R7 (opc 0B, Ra4, Rb3, Rc7):
//     T3 Bus=3 e_Y; T4 Bus=7 ALU_op=1010 e_Z; T5 Bus=19 GP_addr=4 e_GP; instr_done at cycle 6.
//  3. MUL R2,R5 (opc 0E): T5 Bus=19 e_LO; T6 Bus=18 e_HI; no e_GP; instr_done at cycle 7.
//  4. mem_ready low 3 cycles then high: T1 held 4 cycles, MDR_read/e_MDR=1 only on the 4th; no mem_err.
//  5. mem_ready stuck 0: mem_err=1 after MEM_TMO+1 T1 cycles, state IDLE; mem_err holds until reset.
//  6. IR opc 1F -> halted=1 forever; opc 11 -> illegal_op pulse, next cycle T0 (or IDLE with CONTROL_SINGLE_STEP_EN).

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the Mini SRC hardwired control sequencer:
// state encoding, bus select codes, opcodes, ALU codes and decode helpers.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALTED
  } state_e;

  // Bus source selects above the register file (0-15 select R0-R15)
  localparam logic [4:0] BUS_ZHI = 5'd18;
  localparam logic [4:0] BUS_ZLO = 5'd19;
  localparam logic [4:0] BUS_PC  = 5'd20;
  localparam logic [4:0] BUS_MDR = 5'd21;

  localparam logic [4:0] OPC_ADD  = 5'h03;
  localparam logic [4:0] OPC_SUB  = 5'h04;
  localparam logic [4:0] OPC_AND  = 5'h05;
  localparam logic [4:0] OPC_OR   = 5'h06;
  localparam logic [4:0] OPC_SHR  = 5'h07;
  localparam logic [4:0] OPC_SHL  = 5'h08;
  localparam logic [4:0] OPC_SHRA = 5'h09;
  localparam logic [4:0] OPC_ROL  = 5'h0A;
  localparam logic [4:0] OPC_ROR  = 5'h0B;
  localparam logic [4:0] OPC_NEG  = 5'h0C;
  localparam logic [4:0] OPC_NOT  = 5'h0D;
  localparam logic [4:0] OPC_MUL  = 5'h0E;
  localparam logic [4:0] OPC_DIV  = 5'h0F;
  localparam logic [4:0] OPC_HALT = 5'h1F;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SHR  = 4'b0100;
  localparam logic [3:0] ALU_SHL  = 4'b0101;
  localparam logic [3:0] ALU_SHRA = 4'b0110;
  localparam logic [3:0] ALU_NEG  = 4'b0111;
  localparam logic [3:0] ALU_NOT  = 4'b1000;
  localparam logic [3:0] ALU_ROL  = 4'b1001;
  localparam logic [3:0] ALU_ROR  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1100;

  // Opcode to ALU operation; undefined opcodes never reach T4
  function automatic logic [3:0] op_map(input logic [4:0] opc);
    case (opc)
      OPC_ADD:  return ALU_ADD;
      OPC_SUB:  return ALU_SUB;
      OPC_AND:  return ALU_AND;
      OPC_OR:   return ALU_OR;
      OPC_SHR:  return ALU_SHR;
      OPC_SHL:  return ALU_SHL;
      OPC_SHRA: return ALU_SHRA;
      OPC_ROL:  return ALU_ROL;
      OPC_ROR:  return ALU_ROR;
      OPC_NEG:  return ALU_NEG;
      OPC_NOT:  return ALU_NOT;
      OPC_MUL:  return ALU_MUL;
      OPC_DIV:  return ALU_DIV;
      default:  return ALU_ADD;
    endcase
  endfunction

  // MUL/DIV write a 64-bit result through LO then HI
  function automatic logic is_hilo(input logic [4:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  // Executable opcodes form one contiguous range
  function automatic logic is_defined(input logic [4:0] opc);
    return (opc >= OPC_ADD) && (opc <= OPC_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath: fetch T0-T2, execute T3-T6.
// Optional macro CONTROL_SINGLE_STEP_EN: return to IDLE after each instruction
// and restart only on a rising edge of run.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned IR_W      = 32,
  parameter int unsigned BUS_SEL_W = 5,
  parameter int unsigned ALU_OP_W  = 4,
  parameter int unsigned MEM_TMO   = 15
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [IR_W-1:0]      IR,
  output logic                 e_PC,
  output logic                 e_IR,
  output logic                 e_Y,
  output logic                 e_Z,
  output logic                 e_HI,
  output logic                 e_LO,
  output logic                 e_MDR,
  output logic                 e_MAR,
  output logic                 e_GP,
  output logic                 incPC,
  output logic                 MDR_read,
  output logic [ALU_OP_W-1:0]  ALU_op,
  output logic [BUS_SEL_W-1:0] BusDataSelect,
  output logic [3:0]           GP_addr,
  output logic                 instr_done,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 mem_err
);

  localparam int unsigned CNT_W = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               start;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

`ifdef CONTROL_SINGLE_STEP_EN
  localparam state_e DONE_NEXT = ST_IDLE;
  logic run_q;

  // Previous run level, for rising-edge start detection
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) run_q <= 1'b0;
    else        run_q <= run;
  end

  assign start = run & ~run_q;
`else
  localparam state_e DONE_NEXT = ST_T0;
  assign start = run;
`endif

  // State, T1 wait counter and sticky memory error
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  // Next-state and strobe decode from state and IR fields
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = '0;
    BusDataSelect = '0;
    GP_addr       = '0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_T0;
      end
      ST_T0: begin
        BusDataSelect = BUS_SEL_W'(BUS_PC);
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
        state_d       = ST_T1;
      end
      ST_T1: begin
        // PC reload from ZLO repeats harmlessly while waiting on memory
        BusDataSelect = BUS_SEL_W'(BUS_ZLO);
        e_PC          = 1'b1;
        MDR_read      = mem_ready;
        e_MDR         = mem_ready;
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = ST_T2;
        end else if (cnt_q == CNT_W'(MEM_TMO)) begin
          cnt_d     = '0;
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_T2: begin
        BusDataSelect = BUS_SEL_W'(BUS_MDR);
        e_IR          = 1'b1;
        state_d       = ST_T3;
      end
      ST_T3: begin
        if (opc == OPC_HALT) begin
          state_d = ST_HALTED;
        end else if (!is_defined(opc)) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = DONE_NEXT;
        end else begin
          BusDataSelect = BUS_SEL_W'(rb);
          e_Y           = 1'b1;
          state_d       = ST_T4;
        end
      end
      ST_T4: begin
        BusDataSelect = BUS_SEL_W'(rc);
        ALU_op        = ALU_OP_W'(op_map(opc));
        e_Z           = 1'b1;
        state_d       = ST_T5;
      end
      ST_T5: begin
        BusDataSelect = BUS_SEL_W'(BUS_ZLO);
        if (is_hilo(opc)) begin
          e_LO    = 1'b1;
          state_d = ST_T6;
        end else begin
          GP_addr    = ra;
          e_GP       = 1'b1;
          instr_done = 1'b1;
          state_d    = DONE_NEXT;
        end
      end
      ST_T6: begin
        BusDataSelect = BUS_SEL_W'(BUS_ZHI);
        e_HI          = 1'b1;
        instr_done    = 1'b1;
        state_d       = DONE_NEXT;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle comparison of every
// output against an expected micro-step list built from instruction semantics.
module tb_control_sequencer;

  localparam int MEM_TMO = 15;

  logic        clock, clear, run, mem_ready;
  logic [31:0] IR;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read, instr_done, halted, illegal_op, mem_err;
  logic [3:0]  ALU_op, GP_addr;
  logic [4:0]  BusDataSelect;

  control_sequencer #(
    .IR_W(32), .BUS_SEL_W(5), .ALU_OP_W(4), .MEM_TMO(MEM_TMO)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .incPC(incPC),
    .MDR_read(MDR_read), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .GP_addr(GP_addr), .instr_done(instr_done), .halted(halted),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flag bits of the observed/expected snapshot
  localparam logic [14:0] F_PC   = 15'h4000;
  localparam logic [14:0] F_IR   = 15'h2000;
  localparam logic [14:0] F_Y    = 15'h1000;
  localparam logic [14:0] F_Z    = 15'h0800;
  localparam logic [14:0] F_HI   = 15'h0400;
  localparam logic [14:0] F_LO   = 15'h0200;
  localparam logic [14:0] F_MDR  = 15'h0100;
  localparam logic [14:0] F_MAR  = 15'h0080;
  localparam logic [14:0] F_GP   = 15'h0040;
  localparam logic [14:0] F_INC  = 15'h0020;
  localparam logic [14:0] F_MRD  = 15'h0010;
  localparam logic [14:0] F_DONE = 15'h0008;
  localparam logic [14:0] F_HALT = 15'h0004;
  localparam logic [14:0] F_ILL  = 15'h0002;
  localparam logic [14:0] F_ERR  = 15'h0001;

  localparam int TAG_IDLE = 8;
  localparam int TAG_HALT = 9;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [27:0] exp;
    int          tag;
  } item_t;

  typedef struct {
    logic [4:0] opc;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    int         waits;
    int         lat;
    logic [3:0] alu;
  } vec_t;

  item_t      q[$];
  vec_t       tbl[8];
  int         n_cmp, n_bad;
  logic       merr_exp;
  int         lat_cnt, last_lat;
  logic [3:0] last_alu;

  function automatic logic [27:0] snap();
    return {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC,
            MDR_read, instr_done, halted, illegal_op, mem_err,
            ALU_op, BusDataSelect, GP_addr};
  endfunction

  function automatic logic [27:0] mk(input logic [14:0] f, input logic [3:0] alu,
                                     input logic [4:0] bus, input logic [3:0] gp);
    return {f | (merr_exp ? F_ERR : 15'h0), alu, bus, gp};
  endfunction

  // ALU code for each executable opcode; -1 marks undefined
  function automatic int alu_of(input logic [4:0] opc);
    int tab [16];
    tab = '{-1, -1, -1, 0, 1, 2, 3, 4, 5, 6, 9, 10, 7, 8, 11, 12};
    if (opc > 5'h0F) return -1;
    return tab[opc[3:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int tag);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s tag=%0d act=%h exp=%h t=%0t", name, tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic r, input logic mr, input logic [31:0] ir,
                      input logic [27:0] e, input int tag);
    item_t it;
    it.run = r; it.mr = mr; it.ir = ir; it.exp = e; it.tag = tag;
    q.push_back(it);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction starting at T0
  task automatic model_instr(input logic [4:0] opc, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [3:0] rc,
                             input int waits);
    logic [31:0] ir;
    int          a;
    ir = {opc, ra, rb, rc, 15'($urandom)};
    a  = alu_of(opc);
    push(1'b1, 1'b0, ir, mk(F_MAR | F_INC | F_Z, 4'd0, 5'd20, 4'd0), 0);
    for (int i = 0; i < waits; i++)
      push(1'b1, 1'b0, ir, mk(F_PC, 4'd0, 5'd19, 4'd0), 1);
    push(1'b1, 1'b1, ir, mk(F_PC | F_MDR | F_MRD, 4'd0, 5'd19, 4'd0), 1);
    push(1'b1, 1'b0, ir, mk(F_IR, 4'd0, 5'd21, 4'd0), 2);
    if (opc == 5'h1F) begin
      push(1'b1, 1'b0, ir, mk(15'h0, 4'd0, 5'd0, 4'd0), 3);
      for (int i = 0; i < 4; i++)
        push(1'(i % 2), 1'b0, ir, mk(F_HALT, 4'd0, 5'd0, 4'd0), TAG_HALT);
      return;
    end
    if (a < 0) begin
      push(1'b1, 1'b0, ir, mk(F_ILL | F_DONE, 4'd0, 5'd0, 4'd0), 3);
    end else begin
      push(1'b1, 1'b0, ir, mk(F_Y, 4'd0, {1'b0, rb}, 4'd0), 3);
      push(1'b1, 1'b0, ir, mk(F_Z, 4'(a), {1'b0, rc}, 4'd0), 4);
      if (opc == 5'h0E || opc == 5'h0F) begin
        push(1'b1, 1'b0, ir, mk(F_LO, 4'd0, 5'd19, 4'd0), 5);
        push(1'b1, 1'b0, ir, mk(F_HI | F_DONE, 4'd0, 5'd18, 4'd0), 6);
      end else begin
        push(1'b1, 1'b0, ir, mk(F_GP | F_DONE, 4'd0, 5'd19, ra), 5);
      end
    end
`ifdef CONTROL_SINGLE_STEP_EN
    push(1'b0, 1'b0, ir, mk(15'h0, 4'd0, 5'd0, 4'd0), TAG_IDLE);
    push(1'b1, 1'b0, ir, mk(15'h0, 4'd0, 5'd0, 4'd0), TAG_IDLE);
`endif
  endtask

  task automatic push_idle(input logic r);
    push(r, 1'b0, $urandom, mk(15'h0, 4'd0, 5'd0, 4'd0), TAG_IDLE);
  endtask

  // Apply queued steps: drive at the falling edge, compare 1 time unit later
  task automatic play(input int n);
    item_t       it;
    logic [27:0] act;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      it        = q.pop_front();
      run       = it.run;
      mem_ready = it.mr;
      IR        = it.ir;
      #1;
      act = snap();
      if (it.tag == 0) lat_cnt = 1;
      else             lat_cnt++;
      if (instr_done === 1'b1) last_lat = lat_cnt;
      if (e_Z === 1'b1 && incPC === 1'b0) last_alu = ALU_op;
      check("step", 32'(act), 32'(it.exp), it.tag);
      @(negedge clock);
    end
  endtask

  task automatic reset_and_check(input string name);
    run      = 1'b0;
    clear    = 1'b0;
    merr_exp = 1'b0;
    #1;
    check(name, 32'(snap()), 32'h0, TAG_IDLE);
    @(negedge clock);
    clear = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] opc;
    n_cmp = 0; n_bad = 0; merr_exp = 1'b0;
    lat_cnt = 0; last_lat = 0; last_alu = 4'hF;
    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; IR = '0;

    tbl[0] = '{5'h0B, 4'd4,  4'd3,  4'd7,  0, 6, 4'b1010}; // ROR R4,R3,R7
    tbl[1] = '{5'h0E, 4'd0,  4'd2,  4'd5,  0, 7, 4'b1011}; // MUL R2,R5
    tbl[2] = '{5'h03, 4'd1,  4'd2,  4'd3,  3, 9, 4'b0000}; // ADD, 3 wait cycles
    tbl[3] = '{5'h0C, 4'd6,  4'd0,  4'd9,  1, 7, 4'b0111}; // NEG
    tbl[4] = '{5'h0F, 4'd0,  4'd8,  4'd9,  2, 9, 4'b1100}; // DIV
    tbl[5] = '{5'h11, 4'd0,  4'd0,  4'd0,  0, 4, 4'hF};    // undefined: no T4
    tbl[6] = '{5'h07, 4'd15, 4'd14, 4'd13, 0, 6, 4'b0100}; // SHR
    tbl[7] = '{5'h0D, 4'd3,  4'd3,  4'd3,  0, 6, 4'b1000}; // NOT

    @(negedge clock);
    reset_and_check("reset");
    for (int i = 0; i < 3; i++) push_idle(1'b0);
    play(q.size());

    // Directed instruction table
    push_idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      last_lat = 0;
      last_alu = 4'hF;
      model_instr(tbl[i].opc, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].waits);
      play(q.size());
      check("latency", 32'(last_lat), 32'(tbl[i].lat), i);
      check("alu_op", 32'(last_alu), 32'(tbl[i].alu), i);
    end

    // Random instruction stream
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        opc = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 2))
                                          : 5'($urandom_range(16, 30));
      else
        opc = 5'($urandom_range(3, 15));
      model_instr(opc, 4'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 5)));
      play(q.size());
    end

    // Reset while in T4, then no motion until run
    model_instr(5'h03, 4'd1, 4'd2, 4'd3, 0);
    play(4);
    q.delete();
    reset_and_check("reset_mid_t4");
    for (int i = 0; i < 3; i++) push_idle(1'b0);
    push_idle(1'b1);
    model_instr(5'h04, 4'd5, 4'd6, 4'd7, 0);
    play(q.size());

    // mem_ready stuck low: timeout, sticky mem_err
    push(1'b1, 1'b0, 32'h1800_0000, mk(F_MAR | F_INC | F_Z, 4'd0, 5'd20, 4'd0), 0);
    for (int i = 0; i <= MEM_TMO; i++)
      push(1'b1, 1'b0, 32'h1800_0000, mk(F_PC, 4'd0, 5'd19, 4'd0), 1);
    merr_exp = 1'b1;
    for (int i = 0; i < 3; i++) push_idle(1'b0);
    push_idle(1'b1);
    model_instr(5'h05, 4'd2, 4'd4, 4'd6, 1);
    play(q.size());
    reset_and_check("reset_clears_err");

    // HALT holds until reset
    push_idle(1'b1);
    model_instr(5'h1F, 4'd0, 4'd0, 4'd0, 0);
    play(q.size());
    reset_and_check("reset_from_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
